// File: rtl/seg_pkg.sv
// Shared types and defaults for the Segway ride sequencer and its load-cell checker.
package seg_pkg;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    WAIT  = 3'd1,
    SOFT  = 3'd2,
    BAL   = 3'd3,
    STEER = 3'd4
  } ride_state_t;

  localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
  localparam logic [7:0]  WT_HYS_DEF       = 8'h40;

endpackage

// File: rtl/ld_balance_chk.sv
// Load-cell arithmetic: sum, absolute difference, balance test, and the
// hysteretic rider-present register.
module ld_balance_chk
  import seg_pkg::*;
#(
  parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
  parameter logic [7:0]  WT_HYS       = WT_HYS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  output logic [12:0] sum,
  output logic [11:0] diff,
  output logic        balanced,
  output logic        rider_on
);

  localparam logic [12:0] WT_HI = {1'b0, MIN_RIDER_WT} + {5'b0, WT_HYS};
  localparam logic [12:0] WT_LO = {1'b0, MIN_RIDER_WT} - {5'b0, WT_HYS};

  logic rider_on_q;
  logic rider_on_d;

  always_comb begin
    sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
    diff     = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
    balanced = ({1'b0, diff} <= (sum >> 2));
  end

  // Between the two thresholds the flag keeps its previous value.
  always_comb begin
    rider_on_d = rider_on_q;
    if (sum > WT_HI)
      rider_on_d = 1'b1;
    else if (sum < WT_LO)
      rider_on_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rider_on_q <= 1'b0;
    else
      rider_on_q <= rider_on_d;
  end

  assign rider_on = rider_on_q;

endmodule

// File: rtl/segway_ride_seq.sv
// Ride sequencer: power-up, soft-start ramp, balance settling and steering
// enable for the Segway datapath, plus the sticky over-speed alarm.
module segway_ride_seq
  import seg_pkg::*;
#(
  parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
  parameter logic [7:0]  WT_HYS       = WT_HYS_DEF,
  parameter int unsigned SS_DIV       = 16,
  parameter int unsigned STABLE_W     = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwr_on,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic        too_fast,
  output logic        pwr_up,
  output logic [7:0]  ss_tmr,
  output logic        en_steer,
  output logic        rider_on,
  output logic        alarm
);

  localparam int unsigned PRESC_W = (SS_DIV > 1) ? $clog2(SS_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(SS_DIV - 1);
  localparam logic [STABLE_W-1:0] STBL_LAST = {{(STABLE_W-1){1'b1}}, 1'b0};

  ride_state_t         state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [STABLE_W-1:0] stbl_q, stbl_d;
  logic [7:0]          ss_tmr_q, ss_tmr_d;
  logic                pwr_up_q, pwr_up_d;
  logic                en_steer_q, en_steer_d;
  logic                alarm_q, alarm_d;
  logic                balanced;
  logic                rider_on_q;
  logic                entering;
  logic [12:0]         unused_sum;
  logic [11:0]         unused_diff;

  ld_balance_chk #(
    .MIN_RIDER_WT (MIN_RIDER_WT),
    .WT_HYS       (WT_HYS)
  ) u_ld_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .sum      (unused_sum),
    .diff     (unused_diff),
    .balanced (balanced),
    .rider_on (rider_on_q)
  );

  // Next state: local transitions first, then overrides in rising priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OFF:     if (pwr_on) state_d = WAIT;
      WAIT:    if (rider_on_q) state_d = SOFT;
      SOFT:    if (ss_tmr_q == 8'hFF) state_d = BAL;
      BAL:     if (balanced && stbl_q == STBL_LAST) state_d = STEER;
      STEER:   if (!balanced) state_d = BAL;
      default: state_d = OFF;
    endcase
    if (state_q == STEER && too_fast)
      state_d = BAL;
    if (!rider_on_q && (state_q == SOFT || state_q == BAL || state_q == STEER))
      state_d = WAIT;
    if (!pwr_on)
      state_d = OFF;
  end

  always_comb begin
    entering = (state_d != state_q);
    presc_d  = '0;
    stbl_d   = '0;
    ss_tmr_d = ss_tmr_q;
    if (!entering) begin
      if (state_q == SOFT) begin
        if (presc_q == PRESC_MAX) begin
          if (ss_tmr_q != 8'hFF)
            ss_tmr_d = ss_tmr_q + 8'd1;
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end else if (state_q == BAL && balanced) begin
        stbl_d = stbl_q + STABLE_W'(1);
      end
    end
    // A fresh SOFT always ramps from zero; there is no partial-ramp resume.
    case (state_d)
      OFF, WAIT: ss_tmr_d = 8'h00;
      SOFT:      if (entering) ss_tmr_d = 8'h00;
      default:   ss_tmr_d = 8'hFF;
    endcase

    pwr_up_d   = (state_d != OFF);
    en_steer_d = (state_d == STEER);

    alarm_d = alarm_q;
    if (too_fast && pwr_up_q)
      alarm_d = 1'b1;
    if (entering && (state_d == OFF || state_d == WAIT))
      alarm_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= OFF;
      presc_q    <= '0;
      stbl_q     <= '0;
      ss_tmr_q   <= '0;
      pwr_up_q   <= 1'b0;
      en_steer_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      stbl_q     <= stbl_d;
      ss_tmr_q   <= ss_tmr_d;
      pwr_up_q   <= pwr_up_d;
      en_steer_q <= en_steer_d;
      alarm_q    <= alarm_d;
    end
  end

  assign pwr_up   = pwr_up_q;
  assign ss_tmr   = ss_tmr_q;
  assign en_steer = en_steer_q;
  assign rider_on = rider_on_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_segway_ride_seq.sv
// Directed bench for segway_ride_seq with STABLE_W=6 and SS_DIV=16.
module tb_segway_ride_seq;

  logic        clk;
  logic        rst_n;
  logic        pwr_on;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        too_fast;
  logic        pwr_up;
  logic [7:0]  ss_tmr;
  logic        en_steer;
  logic        rider_on;
  logic        alarm;

  int checks;
  int failures;

  segway_ride_seq #(
    .MIN_RIDER_WT (12'h200),
    .WT_HYS       (8'h40),
    .SS_DIV       (16),
    .STABLE_W     (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwr_on   (pwr_on),
    .lft_ld   (lft_ld),
    .rght_ld  (rght_ld),
    .too_fast (too_fast),
    .pwr_up   (pwr_up),
    .ss_tmr   (ss_tmr),
    .en_steer (en_steer),
    .rider_on (rider_on),
    .alarm    (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; pwr_on = 1'b1; lft_ld = 12'h300; rght_ld = 12'h300; too_fast = 1'b0;
    step(3);
    checks++;
    if ({pwr_up, ss_tmr, en_steer, rider_on, alarm} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got %0h expected 0", {pwr_up, ss_tmr, en_steer, rider_on, alarm});
    end
    rst_n = 1'b1;
    step(1);
    checks++;
    if (pwr_up !== 1'b1 || rider_on !== 1'b1 || ss_tmr !== 8'h00) begin
      failures++;
      $display("FAIL post_reset_wait: pwr_up=%0b rider_on=%0b ss_tmr=%0h expected 1 1 0", pwr_up, rider_on, ss_tmr);
    end
    step(1);
    step(4079);
    checks++;
    if (ss_tmr !== 8'hFE) begin
      failures++;
      $display("FAIL ramp_4079: got %0h expected fe", ss_tmr);
    end
    step(1);
    checks++;
    if (ss_tmr !== 8'hFF || en_steer !== 1'b0) begin
      failures++;
      $display("FAIL ramp_4080: ss_tmr=%0h en_steer=%0b expected ff 0", ss_tmr, en_steer);
    end
  endtask

  task automatic test_steer_gate;
    lft_ld = 12'h300; rght_ld = 12'h100;
    step(100);
    checks++;
    if (en_steer !== 1'b0 || ss_tmr !== 8'hFF) begin
      failures++;
      $display("FAIL unbalanced_no_steer: en_steer=%0b ss_tmr=%0h expected 0 ff", en_steer, ss_tmr);
    end
    lft_ld = 12'h300; rght_ld = 12'h300;
    step(62);
    checks++;
    if (en_steer !== 1'b0) begin
      failures++;
      $display("FAIL steer_early_62: got %0b expected 0", en_steer);
    end
    step(1);
    checks++;
    if (en_steer !== 1'b1) begin
      failures++;
      $display("FAIL steer_at_63: got %0b expected 1", en_steer);
    end
  endtask

  task automatic test_too_fast;
    too_fast = 1'b1;
    step(1);
    too_fast = 1'b0;
    checks++;
    if (en_steer !== 1'b0 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL too_fast_edge: en_steer=%0b alarm=%0b expected 0 1", en_steer, alarm);
    end
    step(62);
    checks++;
    if (en_steer !== 1'b0 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL rebal_62: en_steer=%0b alarm=%0b expected 0 1", en_steer, alarm);
    end
    step(1);
    checks++;
    if (en_steer !== 1'b1 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL resteer_alarm_held: en_steer=%0b alarm=%0b expected 1 1", en_steer, alarm);
    end
    // Rider drifts into the hysteresis band, then below it.
    lft_ld = 12'h0E8; rght_ld = 12'h0E8;
    step(1);
    checks++;
    if (rider_on !== 1'b1 || en_steer !== 1'b1) begin
      failures++;
      $display("FAIL band_hold_1d0: rider_on=%0b en_steer=%0b expected 1 1", rider_on, en_steer);
    end
    lft_ld = 12'h0DF; rght_ld = 12'h0E0;
    step(1);
    checks++;
    if (rider_on !== 1'b0 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL step_off_flag: rider_on=%0b alarm=%0b expected 0 1", rider_on, alarm);
    end
    step(1);
    checks++;
    if (pwr_up !== 1'b1 || ss_tmr !== 8'h00 || en_steer !== 1'b0 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL wait_entry: pwr_up=%0b ss_tmr=%0h en_steer=%0b alarm=%0b expected 1 0 0 0",
               pwr_up, ss_tmr, en_steer, alarm);
    end
  endtask

  task automatic test_hysteresis;
    logic [11:0] half [6];
    logic        exp_on [6];
    half   = '{12'h0E0, 12'h120, 12'h128, 12'h0E8, 12'h0E0, 12'h0DF};
    exp_on = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      lft_ld  = half[i];
      rght_ld = (i == 5) ? 12'h0E0 : half[i];
      step(1);
      checks++;
      if (rider_on !== exp_on[i]) begin
        failures++;
        $display("FAIL hyst_step%0d: rider_on=%0b expected %0b", i, rider_on, exp_on[i]);
      end
    end
    step(1);
    checks++;
    if (ss_tmr !== 8'h00 || pwr_up !== 1'b1) begin
      failures++;
      $display("FAIL hyst_back_wait: ss_tmr=%0h pwr_up=%0b expected 0 1", ss_tmr, pwr_up);
    end
  endtask

  task automatic test_pwr_drop_soft;
    lft_ld = 12'h300; rght_ld = 12'h300;
    step(2);
    step(2048);
    checks++;
    if (ss_tmr !== 8'h80 || pwr_up !== 1'b1) begin
      failures++;
      $display("FAIL soft_mid_80: ss_tmr=%0h pwr_up=%0b expected 80 1", ss_tmr, pwr_up);
    end
    pwr_on = 1'b0; too_fast = 1'b1;
    step(1);
    too_fast = 1'b0;
    checks++;
    if ({pwr_up, ss_tmr, en_steer, alarm} !== 11'h000) begin
      failures++;
      $display("FAIL pwr_drop_off: got %0h expected 0", {pwr_up, ss_tmr, en_steer, alarm});
    end
    step(3);
    checks++;
    if (pwr_up !== 1'b0 || alarm !== 1'b0) begin
      failures++;
      $display("FAIL off_stays: pwr_up=%0b alarm=%0b expected 0 0", pwr_up, alarm);
    end
    pwr_on = 1'b1;
  endtask

  task automatic test_reset_mid_steer;
    for (int pass = 0; pass < 2; pass++) begin
      step(1);
      checks++;
      if (pwr_up !== 1'b1 || ss_tmr !== 8'h00) begin
        failures++;
        $display("FAIL seq%0d_wait: pwr_up=%0b ss_tmr=%0h expected 1 0", pass, pwr_up, ss_tmr);
      end
      step(1);
      step(4080);
      checks++;
      if (ss_tmr !== 8'hFF) begin
        failures++;
        $display("FAIL seq%0d_ramp: ss_tmr=%0h expected ff", pass, ss_tmr);
      end
      step(63);
      checks++;
      if (en_steer !== 1'b0) begin
        failures++;
        $display("FAIL seq%0d_bal: en_steer=%0b expected 0", pass, en_steer);
      end
      step(1);
      checks++;
      if (en_steer !== 1'b1) begin
        failures++;
        $display("FAIL seq%0d_steer: en_steer=%0b expected 1", pass, en_steer);
      end
      if (pass == 0) begin
        rst_n = 1'b0; too_fast = 1'b1;
        step(1);
        rst_n = 1'b1; too_fast = 1'b0;
        checks++;
        if ({pwr_up, ss_tmr, en_steer, rider_on, alarm} !== 12'h000) begin
          failures++;
          $display("FAIL rst_mid_steer: got %0h expected 0", {pwr_up, ss_tmr, en_steer, rider_on, alarm});
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_steer_gate();
    test_too_fast();
    test_hysteresis();
    test_pwr_drop_soft();
    test_reset_mid_steer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
